ones_count_seq: RTL

//  Sequencer for the 3-input switch-level ones counter (a,b,c -> y1,y0).

---
 rtl/ones_count_seq.sv | 99 +++++++++
 1 files changed

// File: rtl/ones_count_seq.sv
// Sequencer that popcounts a word through a 3-input switch-level ones counter,
// three bits per group, and flags any sample that disagrees with the group popcount.
module ones_count_seq #(
   parameter int WIDTH  = 12,
   parameter int SETTLE = 2,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    count,
   output logic             err,
   output logic             oc_a,
   output logic             oc_b,
   output logic             oc_c,
   input  logic             oc_y1,
   input  logic             oc_y0
);

   localparam int G  = (WIDTH + 2) / 3;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] shadow;
   logic [GW-1:0]    grp;
   logic [TW-1:0]    cnt;

   logic [3*G-1:0]   pad;
   logic [2:0]       grp_bits;
   logic [1:0]       samp;
   logic [1:0]       exp_pc;

   // Bits past WIDTH in the last group read as zero padding.
   always_comb begin
      pad = '0;
      pad[WIDTH-1:0] = shadow;
      grp_bits = 3'(pad >> (3 * int'(grp)));
   end

   assign samp   = {oc_y1, oc_y0};
   assign exp_pc = {1'b0, grp_bits[0]} + {1'b0, grp_bits[1]}
                 + {1'b0, grp_bits[2]};

   assign {oc_c, oc_b, oc_a} = (state == WAIT) ? grp_bits : 3'b000;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         shadow <= '0;
         grp    <= '0;
         cnt    <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shadow <= data_in;
                  grp    <= '0;
                  cnt    <= TW'(SETTLE - 1);
                  count  <= '0;
                  err    <= 1'b0;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  count <= count + CW'(samp);
                  // Case inequality so X/Z from the netlist also flags.
                  if (samp !== exp_pc)
                     err <= 1'b1;
                  if (grp == GW'(G - 1)) begin
                     state <= DONE;
                  end else begin
                     grp <= grp + 1'b1;
                     cnt <= TW'(SETTLE - 1);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
